// File: rtl/sisc_mc_core.sv
// sisc_mc_core: multi-cycle SISC core (decode FSM, register file, ALU, status).
// One instruction is accepted through a valid/ready handshake and then runs
// through DECODE, EXECUTE and WRITEBACK before the core returns to IDLE.
module sisc_mc_core #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [31:0]       ir,
    input  logic              ir_valid,
    output logic              ir_ready,
    output logic              done,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        stat,
    input  logic [3:0]        dbg_addr,
    output logic [DWIDTH-1:0] dbg_data
);

    localparam int SHW = $clog2(DWIDTH);
    localparam int MSB = DWIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    state_t            state_q;
    logic [31:0]       ir_q;
    logic              ir_ready_q, done_q, halted_q, illegal_q;
    logic              legal_q, alu_q, wr_q;
    // Sized for the full 4-bit index; entries at or above NREGS are never written.
    logic [DWIDTH-1:0] regs_q [16];
    logic [DWIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]        flags_q, stat_q;

    logic [3:0]        op, fn, rd, rs, rt;
    logic              is_alu;
    logic [DWIDTH-1:0] imm_ext, rs_val, rt_val;
    logic [SHW-1:0]    sh;
    logic [DWIDTH:0]   sum, diff, shl;
    logic [DWIDTH-1:0] alu_res_d;
    logic              c_d, v_d;
    logic [3:0]        flags_d;

    assign op      = ir_q[31:28];
    assign fn      = ir_q[27:24];
    assign rd      = ir_q[23:20];
    assign rs      = ir_q[19:16];
    assign rt      = ir_q[15:12];
    assign imm_ext = DWIDTH'(signed'(ir_q[15:0]));
    assign is_alu  = ((op == 4'd1) || (op == 4'd2)) && (fn <= 4'd9);
    assign sh      = b_q[SHW-1:0];

    assign ir_ready = ir_ready_q;
    assign done     = done_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;
    assign stat     = stat_q;

    // R0 and indices beyond the implemented range behave as constant zero.
    function automatic logic idx_ok(input logic [3:0] idx);
        return (idx != 4'd0) && (int'(idx) < NREGS);
    endfunction

    // Register file read ports: two operand ports plus the debug port.
    always_comb begin
        rs_val   = idx_ok(rs) ? regs_q[rs] : '0;
        rt_val   = idx_ok(rt) ? regs_q[rt] : '0;
        dbg_data = idx_ok(dbg_addr) ? regs_q[dbg_addr] : '0;
    end

    // ALU: result and {C,V,N,Z} from the latched operands.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        shl       = {1'b0, a_q} << sh;
        alu_res_d = '0;
        c_d       = 1'b0;
        v_d       = 1'b0;
        case (fn)
            4'd0: begin
                alu_res_d = sum[MSB:0];
                c_d       = sum[DWIDTH];
                v_d       = (a_q[MSB] == b_q[MSB]) && (alu_res_d[MSB] != a_q[MSB]);
            end
            4'd1, 4'd9: begin
                alu_res_d = diff[MSB:0];
                c_d       = ~diff[DWIDTH];
                v_d       = (a_q[MSB] != b_q[MSB]) && (alu_res_d[MSB] != a_q[MSB]);
            end
            4'd2: alu_res_d = a_q & b_q;
            4'd3: alu_res_d = a_q | b_q;
            4'd4: alu_res_d = a_q ^ b_q;
            4'd5: alu_res_d = ~a_q;
            4'd6: begin
                alu_res_d = shl[MSB:0];
                c_d       = shl[DWIDTH];
            end
            4'd7: alu_res_d = a_q >> sh;
            4'd8: alu_res_d = DWIDTH'($signed(a_q) >>> sh);
            default: ;
        endcase
        flags_d = {c_d, v_d, alu_res_d[MSB], (alu_res_d == '0)};
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            ir_ready_q <= 1'b1;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            legal_q    <= 1'b0;
            alu_q      <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ir_valid) begin
                        ir_q       <= ir;
                        ir_ready_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    legal_q <= is_alu || (op == 4'd0) || (op == 4'd15);
                    alu_q   <= is_alu;
                    wr_q    <= is_alu && (fn != 4'd9);
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    done_q    <= 1'b1;
                    illegal_q <= ~legal_q;
                    state_q   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (op == 4'd15) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else begin
                        ir_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand latch, ALU result capture, register and status writeback.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            stat_q  <= '0;
        end else begin
            case (state_q)
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= (op == 4'd2) ? imm_ext : rt_val;
                end
                S_EXECUTE: begin
                    res_q   <= alu_res_d;
                    flags_q <= flags_d;
                end
                S_WRITEBACK: begin
                    if (wr_q && idx_ok(rd)) regs_q[rd] <= res_q;
                    if (alu_q) stat_q <= flags_q;
                end
                default: ;
            endcase
        end
    end

endmodule
